// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with stall/flush control, a carry-state channel
// for multi-cycle ops, and saturating bubble/hold counters.
module pipe_stage_reg #(
  parameter int DATA_W  = 108,
  parameter int STATE_W = 66,
  parameter int STALL_W = 6,
  parameter int UP_IDX  = 3,
  parameter int DN_IDX  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [STATE_W-1:0] state_i,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt
);

  if ((DN_IDX != UP_IDX + 1) || (UP_IDX >= STALL_W) || (DN_IDX >= STALL_W)) begin : g_bad_idx
    $error("pipe_stage_reg: DN_IDX must equal UP_IDX+1 and both must be below STALL_W");
  end

  typedef enum logic [1:0] {
    CYC_ADVANCE,
    CYC_BUBBLE,
    CYC_HOLD,
    CYC_FLUSH
  } cyc_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic               up;
  logic               dn;
  logic               stall_unused;
  cyc_e               cyc;

  logic               out_valid_d, out_valid_q;
  logic [DATA_W-1:0]  out_data_d,  out_data_q;
  logic [STATE_W-1:0] state_d,     state_q;
  logic [CNT_W-1:0]   bubble_d,    bubble_q;
  logic [CNT_W-1:0]   hold_d,      hold_q;

  assign up           = stall[UP_IDX];
  assign dn           = stall[DN_IDX];
  assign stall_unused = ^stall;

  // Cycle classification: flush beats every stall pattern; up=0 always advances.
  always_comb begin
    cyc = CYC_ADVANCE;
    if (flush) begin
      cyc = CYC_FLUSH;
    end else if (up && !dn) begin
      cyc = CYC_BUBBLE;
    end else if (up) begin
      cyc = CYC_HOLD;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    state_d     = state_q;
    bubble_d    = bubble_q;
    hold_d      = hold_q;
    unique case (cyc)
      CYC_FLUSH: begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        state_d     = '0;
        hold_d      = '0;
      end
      CYC_BUBBLE: begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
        state_d     = state_i;
        bubble_d    = sat_inc(bubble_q);
        hold_d      = '0;
      end
      CYC_HOLD: begin
        state_d = state_i;
        hold_d  = sat_inc(hold_q);
      end
      default: begin
        out_valid_d = in_valid;
        out_data_d  = in_data;
        state_d     = '0;
        hold_d      = '0;
      end
    endcase
    if (cnt_clr) begin
      bubble_d = '0;
      hold_d   = '0;
    end
  end

  // Boundary register: everything, carry-state included, clears on reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      state_q     <= '0;
      bubble_q    <= '0;
      hold_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      state_q     <= state_d;
      bubble_q    <= bubble_d;
      hold_q      <= hold_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign state_o    = state_q;
  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver queues hand-computed expected
// outputs, and a monitor compares them one cycle later.
module tb_pipe_stage_reg;
  localparam int DW = 108;
  localparam int SW = 66;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [SW-1:0] state_i;
  logic          cnt_clr;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] state_o;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] hold_cnt;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [CW-1:0] b;
    logic [CW-1:0] h;
    string         nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] ST_RUN  = 6'b000000;
  localparam logic [5:0] ST_HOLD = 6'b011111;
  localparam logic [5:0] ST_BUB  = 6'b001111;

  pipe_stage_reg #(
    .DATA_W(DW), .STATE_W(SW), .STALL_W(6), .UP_IDX(3), .DN_IDX(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .state_i(state_i), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_data(out_data), .state_o(state_o),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string f, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      cmp(mon_e.nm, "out_valid",  128'(out_valid),  128'(mon_e.v));
      cmp(mon_e.nm, "out_data",   128'(out_data),   128'(mon_e.d));
      cmp(mon_e.nm, "state_o",    128'(state_o),    128'(mon_e.s));
      cmp(mon_e.nm, "bubble_cnt", 128'(bubble_cnt), 128'(mon_e.b));
      cmp(mon_e.nm, "hold_cnt",   128'(hold_cnt),   128'(mon_e.h));
    end
  end

  task automatic drive(input logic r, input logic [5:0] st, input logic fl, input logic v,
                       input logic [DW-1:0] d, input logic [SW-1:0] si, input logic clr,
                       input logic ev, input logic [DW-1:0] ed, input logic [SW-1:0] es,
                       input logic [CW-1:0] eb, input logic [CW-1:0] eh, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; flush = fl; in_valid = v; in_data = d; state_i = si; cnt_clr = clr;
    e.v = ev; e.d = ed; e.s = es; e.b = eb; e.h = eh; e.nm = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] ones_d;
    logic [SW-1:0] ones_s;
    logic [SW-1:0] st2;
    logic [CW-1:0] eb;
    ones_d = '1;
    ones_s = '1;
    st2    = 66'h1_0000_0000_0000_0002;
    rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; state_i = '0; cnt_clr = 1'b0;

    drive(0, ST_RUN, 0, 1, ones_d, ones_s, 0, 0, 0, 0, 0, 0, "rst1");
    drive(0, ST_RUN, 0, 1, ones_d, ones_s, 0, 0, 0, 0, 0, 0, "rst2");
    drive(1, ST_RUN, 0, 1, 'hA5, 0, 0, 1, 'hA5, 0, 0, 0, "release");
    drive(1, ST_RUN, 0, 1, 'h11, 0, 0, 1, 'h11, 0, 0, 0, "adv11");
    drive(1, ST_RUN, 0, 1, 'h22, 0, 0, 1, 'h22, 0, 0, 0, "adv22");
    drive(1, ST_HOLD, 0, 1, 'h33, 'h5, 0, 1, 'h22, 'h5, 0, 1, "hold1");
    drive(1, ST_HOLD, 0, 1, 'h33, 'h5, 0, 1, 'h22, 'h5, 0, 2, "hold2");
    drive(1, ST_HOLD, 0, 1, 'h33, 'h5, 0, 1, 'h22, 'h5, 0, 3, "hold3");
    drive(1, ST_RUN, 0, 1, 'h33, 'h5, 0, 1, 'h33, 0, 0, 0, "adv33");
    drive(1, ST_BUB, 0, 1, 'h34, st2, 0, 0, 0, st2, 1, 0, "bub1");
    drive(1, ST_BUB, 0, 1, 'h34, st2, 0, 0, 0, st2, 2, 0, "bub2");
    drive(1, ST_RUN, 0, 1, 'h44, st2, 0, 1, 'h44, 0, 2, 0, "adv44");
    drive(1, ST_HOLD, 0, 1, 'h55, 'h7, 0, 1, 'h44, 'h7, 2, 1, "hold44");
    drive(1, ST_HOLD, 1, 1, 'h55, 'h7, 0, 0, 0, 0, 2, 0, "flush");
    drive(1, ST_RUN, 0, 0, 'h66, 'h7, 0, 0, 'h66, 0, 2, 0, "adv_novalid");

    for (int i = 1; i <= 20; i++) begin
      eb = (2 + i > 15) ? 4'd15 : 4'(2 + i);
      drive(1, ST_BUB, 0, 1, 'h70, 'h9, 0, 0, 0, 'h9, eb, 0, "bub_sat");
    end
    drive(1, ST_BUB, 0, 1, 'h70, 'h9, 1, 0, 0, 'h9, 0, 0, "bub_clr");

    drive(1, ST_RUN, 0, 1, 'h77, 'h9, 0, 1, 'h77, 0, 0, 0, "adv77");
    for (int i = 1; i <= 18; i++) begin
      drive(1, ST_HOLD, 0, 1, 'h78, 'h3, 0, 1, 'h77, 'h3, 0,
            (i > 15) ? 4'd15 : 4'(i), "hold_sat");
    end
    drive(1, ST_HOLD, 0, 1, 'h78, 'h3, 1, 1, 'h77, 'h3, 0, 0, "hold_clr");

    drive(1, ST_RUN, 0, 1, 'h88, 0, 0, 1, 'h88, 0, 0, 0, "adv88");
    drive(1, ST_HOLD, 0, 1, 'h89, 'hABC, 0, 1, 'h88, 'hABC, 0, 1, "op_hold1");
    drive(1, ST_HOLD, 0, 1, 'h89, 'hABC, 0, 1, 'h88, 'hABC, 0, 2, "op_hold2");
    drive(0, ST_HOLD, 0, 1, 'h89, 'hABC, 0, 0, 0, 0, 0, 0, "rst_midop");
    drive(1, ST_RUN, 0, 1, 'h99, 'hABC, 0, 1, 'h99, 0, 0, 0, "adv99");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
